bht_2bit: RTL and testbench
===========================

BHT_2BIT -- requirements
Module: bht_2bit

Interface
REQ-001 SHALL provide parameter INIT_STATE, default 2'b01, as the counter value loaded into every entry on reset (weakly not-taken).
REQ-002 SHALL provide parameter CNT_W, default 8, as the width of MISS_COUNT.
REQ-003 SHALL have port CLOCK  input  1  as the single clock; all state updates on its rising edge.
REQ-004 SHALL have port INIT  input  1  as the synchronous, active-high reset, sampled on the CLOCK rising edge.
REQ-005 SHALL have port RD_EN  input  1  as the lookup request for the current fetch.
REQ-006 SHALL have port RD_ADDR  input  3  as the lookup index.
REQ-007 SHALL have port PREDICTION  output  1  as the registered taken/not-taken prediction.
REQ-008 SHALL have port PRED_VALID  output  1  as the qualifier that PREDICTION answers the previous-cycle RD_EN.
REQ-009 SHALL have port RD_STATE  output  2  as the registered counter value behind PREDICTION.
REQ-010 SHALL have port UPD_EN  input  1  as the update strobe from the comparator stage.
REQ-011 SHALL have port UPD_ADDR  input  3  as the entry to update, driven by the comparator's ADDR_W.
REQ-012 SHALL have port OUTCOME  input  1  as the resolved branch direction (1 = taken).
REQ-013 SHALL have port MISS  input  1  as the comparator's mispredict flag for this update.
REQ-014 SHALL have port MISS_COUNT  output  CNT_W  as the saturating mispredict total since reset.

Function
REQ-015 SHALL hold 8 entries, each a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 SHALL, on a clock edge with UPD_EN=1 and INIT=0, increment entry[UPD_ADDR] when OUTCOME=1 (saturating at 11) and decrement it when OUTCOME=0 (saturating at 00).
REQ-017 SHALL leave all entries unchanged on any edge with UPD_EN=0.
REQ-018 SHALL, on an edge with RD_EN=1, register RD_STATE <= entry[RD_ADDR] and PREDICTION <= entry[RD_ADDR][1], giving 1-cycle lookup latency.
REQ-019 SHALL set PRED_VALID <= RD_EN on every non-reset edge.
REQ-020 SHALL hold PREDICTION and RD_STATE at their previous values on an edge with RD_EN=0.
REQ-021 SHALL, when RD_EN=1, UPD_EN=1 and RD_ADDR=UPD_ADDR on the same edge, bypass: register the post-update counter value, not the stale one.
REQ-022 SHALL, when RD_ADDR differs from UPD_ADDR, perform the read and the update independently on the same edge.
REQ-023 SHALL increment MISS_COUNT by 1 on an edge with UPD_EN=1 and MISS=1, saturating at all-ones (no wrap).
REQ-024 SHALL ignore MISS when UPD_EN=0.
REQ-025 SHALL apply the counter update regardless of MISS; MISS affects only MISS_COUNT.

Reset
REQ-026 SHALL, on an edge with INIT=1, load all 8 entries with INIT_STATE, clear PREDICTION, PRED_VALID and MISS_COUNT to 0, and set RD_STATE to INIT_STATE.
REQ-027 SHALL give INIT priority over UPD_EN and RD_EN on the same edge, discarding both.
REQ-028 SHALL resume normal operation on the first edge after INIT deasserts, with no extra idle cycles.

Verification
REQ-029 SHALL pass this scenario: INIT for 1 cycle, then RD_EN=1, RD_ADDR=5 -> next cycle PRED_VALID=1, PREDICTION=0, RD_STATE=01, MISS_COUNT=0.
REQ-030 SHALL pass this scenario: 3 updates to addr 2 with OUTCOME=1, then read addr 2 -> RD_STATE 01->10->11->11 (saturates), PREDICTION=1.
REQ-031 SHALL pass this scenario: 2 updates to addr 2 with OUTCOME=0 from 11, then read -> RD_STATE=01, PREDICTION=0; 2 more decrements -> 00, held.
REQ-032 SHALL pass this scenario: same-edge RD_EN=1, UPD_EN=1, addr 4, OUTCOME=1, entry 01 -> next cycle RD_STATE=10, PREDICTION=1 (bypass).
REQ-033 SHALL pass this scenario: CNT_W=2, 5 edges with UPD_EN=1, MISS=1 -> MISS_COUNT 1,2,3,3,3; an edge with MISS=1, UPD_EN=0 -> no change.
REQ-034 SHALL pass this scenario: INIT=1 on the same edge as UPD_EN=1 to addr 1 -> entry 1=INIT_STATE and MISS_COUNT=0 after the edge.

Source files
------------

// File: rtl/bht_2bit.sv
// 8-entry branch history table of 2-bit saturating counters.
// Registered lookup with same-edge update bypass and a mispredict counter.
module bht_2bit #(
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLOCK,
    input  logic             INIT,
    input  logic             RD_EN,
    input  logic [2:0]       RD_ADDR,
    output logic             PREDICTION,
    output logic             PRED_VALID,
    output logic [1:0]       RD_STATE,
    input  logic             UPD_EN,
    input  logic [2:0]       UPD_ADDR,
    input  logic             OUTCOME,
    input  logic             MISS,
    output logic [CNT_W-1:0] MISS_COUNT
);

    localparam int unsigned N_ENT = 8;
    localparam logic [CNT_W-1:0] MISS_MAX = '1;

    logic [N_ENT-1:0][1:0] cnt_q;
    logic [N_ENT-1:0][1:0] cnt_d;
    logic [1:0]            rd_state_q;
    logic [1:0]            rd_state_d;
    logic                  pred_q;
    logic                  pred_d;
    logic                  pred_valid_q;
    logic                  pred_valid_d;
    logic [CNT_W-1:0]      miss_cnt_q;
    logic [CNT_W-1:0]      miss_cnt_d;

    logic [1:0]            upd_old;
    logic [1:0]            upd_new;
    logic [1:0]            rd_val;
    logic                  rd_hit_upd;

    // Saturating step of the entry being trained.
    always_comb begin
        upd_old = cnt_q[UPD_ADDR];
        upd_new = upd_old;
        if (OUTCOME) begin
            if (upd_old != 2'b11) begin
                upd_new = upd_old + 2'b01;
            end
        end else begin
            if (upd_old != 2'b00) begin
                upd_new = upd_old - 2'b01;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (UPD_EN) begin
            cnt_d[UPD_ADDR] = upd_new;
        end
    end

    // A read of the entry being updated sees the post-update value.
    always_comb begin
        rd_hit_upd = UPD_EN && (RD_ADDR == UPD_ADDR);
        rd_val     = rd_hit_upd ? upd_new : cnt_q[RD_ADDR];
    end

    always_comb begin
        rd_state_d   = rd_state_q;
        pred_d       = pred_q;
        pred_valid_d = RD_EN;
        if (RD_EN) begin
            rd_state_d = rd_val;
            pred_d     = rd_val[1];
        end
    end

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (UPD_EN && MISS && (miss_cnt_q != MISS_MAX)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (INIT) begin
            for (int i = 0; i < N_ENT; i++) begin
                cnt_q[i] <= INIT_STATE;
            end
            rd_state_q   <= INIT_STATE;
            pred_q       <= 1'b0;
            pred_valid_q <= 1'b0;
            miss_cnt_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rd_state_q   <= rd_state_d;
            pred_q       <= pred_d;
            pred_valid_q <= pred_valid_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign PREDICTION = pred_q;
    assign PRED_VALID = pred_valid_q;
    assign RD_STATE   = rd_state_q;
    assign MISS_COUNT = miss_cnt_q;

endmodule

// File: tb/tb_bht_2bit.sv
// Directed bench for bht_2bit: counter training, bypass, miss count, reset.
// A second instance with CNT_W=2 checks miss-count saturation.
module tb_bht_2bit;

    logic       clk = 1'b0;
    logic       init;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       upd_en;
    logic [2:0] upd_addr;
    logic       outcome;
    logic       miss;

    logic       pred;
    logic       pv;
    logic [1:0] rs;
    logic [7:0] mc;
    logic       pred2;
    logic       pv2;
    logic [1:0] rs2;
    logic [1:0] mc2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bht_2bit u_dut (
        .CLOCK      (clk),
        .INIT       (init),
        .RD_EN      (rd_en),
        .RD_ADDR    (rd_addr),
        .PREDICTION (pred),
        .PRED_VALID (pv),
        .RD_STATE   (rs),
        .UPD_EN     (upd_en),
        .UPD_ADDR   (upd_addr),
        .OUTCOME    (outcome),
        .MISS       (miss),
        .MISS_COUNT (mc)
    );

    bht_2bit #(.CNT_W(2)) u_dut2 (
        .CLOCK      (clk),
        .INIT       (init),
        .RD_EN      (rd_en),
        .RD_ADDR    (rd_addr),
        .PREDICTION (pred2),
        .PRED_VALID (pv2),
        .RD_STATE   (rs2),
        .UPD_EN     (upd_en),
        .UPD_ADDR   (upd_addr),
        .OUTCOME    (outcome),
        .MISS       (miss),
        .MISS_COUNT (mc2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        init   = 1'b0;
        rd_en  = 1'b0;
        upd_en = 1'b0;
        miss   = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [2:0] a, input logic o, input logic m);
        idle();
        upd_en   = 1'b1;
        upd_addr = a;
        outcome  = o;
        miss     = m;
        cyc();
    endtask

    task automatic rd(input logic [2:0] a);
        idle();
        rd_en   = 1'b1;
        rd_addr = a;
        cyc();
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] st);
        chk({tag, "_pv"}, 32'(pv), 32'd1);
        chk({tag, "_st"}, 32'(rs), 32'(st));
        chk({tag, "_pr"}, 32'(pred), 32'(st[1]));
    endtask

    initial begin
        idle();
        rd_addr  = 3'd0;
        upd_addr = 3'd0;
        outcome  = 1'b0;

        init = 1'b1;
        cyc();
        chk("rst_pv", 32'(pv), 32'd0);
        chk("rst_pr", 32'(pred), 32'd0);
        chk("rst_st", 32'(rs), 32'd1);
        chk("rst_mc", 32'(mc), 32'd0);

        rd(3'd5);
        chk_rd("rd5", 2'b01);
        chk("rd5_mc", 32'(mc), 32'd0);

        upd(3'd2, 1'b1, 1'b0);
        chk("hold_pv", 32'(pv), 32'd0);
        chk("hold_st", 32'(rs), 32'd1);
        rd(3'd2);
        chk_rd("inc1", 2'b10);
        upd(3'd2, 1'b1, 1'b0);
        rd(3'd2);
        chk_rd("inc2", 2'b11);
        upd(3'd2, 1'b1, 1'b0);
        rd(3'd2);
        chk_rd("inc_sat", 2'b11);

        upd(3'd2, 1'b0, 1'b0);
        upd(3'd2, 1'b0, 1'b0);
        rd(3'd2);
        chk_rd("dec2", 2'b01);
        upd(3'd2, 1'b0, 1'b0);
        upd(3'd2, 1'b0, 1'b0);
        rd(3'd2);
        chk_rd("dec_sat", 2'b00);

        idle();
        rd_en    = 1'b1;
        rd_addr  = 3'd4;
        upd_en   = 1'b1;
        upd_addr = 3'd4;
        outcome  = 1'b1;
        cyc();
        chk_rd("bypass", 2'b10);

        idle();
        rd_en    = 1'b1;
        rd_addr  = 3'd2;
        upd_en   = 1'b1;
        upd_addr = 3'd4;
        outcome  = 1'b1;
        cyc();
        chk_rd("indep_rd", 2'b00);
        rd(3'd4);
        chk_rd("indep_up", 2'b11);

        for (int i = 1; i <= 5; i++) begin
            upd(3'd7, 1'b0, 1'b1);
            chk($sformatf("mc_%0d", i), 32'(mc), 32'(i));
            chk($sformatf("mc2_%0d", i), 32'(mc2), (i > 3) ? 32'd3 : 32'(i));
        end
        idle();
        miss = 1'b1;
        cyc();
        chk("mc_noupd", 32'(mc), 32'd5);
        chk("mc2_noupd", 32'(mc2), 32'd3);
        rd(3'd7);
        chk_rd("miss_dec", 2'b00);

        upd(3'd6, 1'b1, 1'b1);
        chk("mc_6", 32'(mc), 32'd6);
        rd(3'd6);
        chk_rd("miss_inc", 2'b10);

        idle();
        init     = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 3'd6;
        upd_en   = 1'b1;
        upd_addr = 3'd1;
        outcome  = 1'b1;
        miss     = 1'b1;
        cyc();
        chk("init_pv", 32'(pv), 32'd0);
        chk("init_pr", 32'(pred), 32'd0);
        chk("init_st", 32'(rs), 32'd1);
        chk("init_mc", 32'(mc), 32'd0);
        chk("init_mc2", 32'(mc2), 32'd0);
        rd(3'd1);
        chk_rd("init_e1", 2'b01);
        rd(3'd4);
        chk_rd("init_e4", 2'b01);
        rd(3'd6);
        chk_rd("init_e6", 2'b01);

        idle();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
